vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 The block SHALL have parameter PRICE, default 3, meaning the item price in coin units; legal range 1..14.
REQ-002 The block SHALL have parameter TIMEOUT, default 200, meaning the idle cycles allowed in COLLECT before auto-refund; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port coin, input, 2 bits: coin code sampled every cycle (00 none, 01 one unit, 10 two units, 11 invalid).
REQ-006 The block SHALL have port cancel, input, 1 bit: customer cancel request, sampled every cycle.
REQ-007 The block SHALL have port disp_ack, input, 1 bit: dispenser acknowledge.
REQ-008 The block SHALL have port chg_ack, input, 1 bit: change-unit acknowledge, one coin unit returned per ack.
REQ-009 The block SHALL have port disp_req, output, 1 bit: dispense request.
REQ-010 The block SHALL have port chg_req, output, 1 bit: change or refund request.
REQ-011 The block SHALL have port credit, output, 4 bits: current credit in coin units.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port coin_rej, output, 1 bit: one-cycle pulse when a coin code is rejected.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, DISPENSE and CHANGE.
REQ-016 In IDLE, coin 01 or 10 SHALL add 1 or 2 to credit and move to COLLECT; if the added value is already >= PRICE, the move SHALL follow REQ-018 instead.
REQ-017 In COLLECT, each valid coin SHALL add its value to credit and reset the timeout counter; a cycle without a valid coin SHALL increment the counter.
REQ-018 In IDLE or COLLECT, when credit+coin >= PRICE, the next cycle SHALL have credit = credit+coin-PRICE, state DISPENSE and disp_req = 1.
REQ-019 In COLLECT, cancel = 1 SHALL go to CHANGE with credit = credit+coin; cancel SHALL take priority over REQ-018.
REQ-020 In COLLECT, when the timeout counter reaches TIMEOUT, the state SHALL go to CHANGE with credit unchanged.
REQ-021 In IDLE, cancel SHALL be ignored.
REQ-022 In DISPENSE, disp_req SHALL hold high until disp_ack is sampled high; on that edge disp_req SHALL drop, and the state SHALL go to CHANGE if credit > 0, else to IDLE.
REQ-023 In CHANGE, chg_req SHALL be 1 while credit > 0.
REQ-024 In CHANGE, each cycle with chg_req & chg_ack SHALL decrement credit by 1.
REQ-025 In CHANGE, the edge on which credit becomes 0 SHALL also clear chg_req and return the state to IDLE.
REQ-026 chg_ack with chg_req low SHALL be ignored; disp_ack outside DISPENSE SHALL be ignored.
REQ-027 Coin code 11 in any state SHALL be ignored for credit and SHALL pulse coin_rej.
REQ-028 Any nonzero coin in DISPENSE or CHANGE SHALL be ignored for credit and SHALL pulse coin_rej.
REQ-029 Credit SHALL never exceed PRICE+1 and SHALL never underflow.
REQ-030 disp_req and chg_req SHALL never be high in the same cycle.
REQ-031 The timeout counter SHALL be 8 bits and SHALL clear on entry to COLLECT and on leaving it.

Reset
REQ-032 While rst = 1, asynchronously: state = IDLE; credit, disp_req, chg_req, busy, coin_rej and the timeout counter = 0.
REQ-033 Reset mid-transaction SHALL discard credit without refund.
REQ-034 Operation SHALL resume on the first clk edge after rst falls.

Verification (PRICE = 3, TIMEOUT = 200)
REQ-035 Exact pay: coins 01,01,01 on consecutive cycles -> credit 1, 2, then 0 with disp_req = 1; disp_ack -> IDLE; chg_req never asserted.
REQ-036 Overpay: coins 10,10 -> credit 2, then 1 with disp_req; disp_ack -> chg_req = 1; one chg_ack -> credit 0, chg_req = 0, busy = 0.
REQ-037 Cancel: coin 01, then cancel with coin 10 in the same cycle -> CHANGE with credit 3, disp_req never 1; three chg_acks -> IDLE.
REQ-038 Timeout: coin 01, then 200 idle cycles -> CHANGE with credit 1, chg_req = 1.
REQ-039 Rejects: coin 11 in IDLE, then coin 01 during DISPENSE -> two coin_rej pulses; credit unchanged.
REQ-040 Async reset: rst asserted mid-cycle during DISPENSE with credit 1 -> disp_req, credit and busy = 0 before the next clk edge.

Source files
------------

// File: rtl/vend_sequencer_if.sv
// rtl/vend_sequencer_if.sv - customer/dispenser/change-unit signal bundle for vend_sequencer
interface vend_sequencer_if;
  logic [1:0] coin;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic       chg_req;
  logic [3:0] credit;
  logic       busy;
  logic       coin_rej;

  modport master (
    output coin, cancel, disp_ack, chg_ack,
    input  disp_req, chg_req, credit, busy, coin_rej
  );

  modport slave (
    input  coin, cancel, disp_ack, chg_ack,
    output disp_req, chg_req, credit, busy, coin_rej
  );
endinterface

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - coin-collecting vending sequencer: collect, dispense, return change
module vend_sequencer #(
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 200
) (
  input logic             clk,
  input logic             rst,
  vend_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam logic [4:0] LP_PRICE    = 5'(PRICE);
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_credit;
  logic [3:0] w_credit_nxt;
  logic [7:0] r_tmo;
  logic [7:0] w_tmo_nxt;
  logic       r_disp_req;
  logic       r_chg_req;
  logic       r_busy;
  logic       r_coin_rej;

  logic [4:0] w_coin_val;
  logic [4:0] w_sum;
  logic       w_paid;
  logic       w_coin_rej;

  always_comb begin
    w_coin_val = 5'd0;
    case (bus.coin)
      2'b01:   w_coin_val = 5'd1;
      2'b10:   w_coin_val = 5'd2;
      default: w_coin_val = 5'd0;
    endcase
  end

  assign w_sum  = {1'b0, r_credit} + w_coin_val;
  assign w_paid = (w_sum >= LP_PRICE);

  // Coins are only accepted while collecting; anything offered later is bounced.
  assign w_coin_rej = (bus.coin == 2'b11) ||
                      ((bus.coin != 2'b00) &&
                       ((r_state == ST_DISPENSE) || (r_state == ST_CHANGE)));

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_tmo_nxt    = r_tmo;
    case (r_state)
      ST_IDLE: begin
        w_tmo_nxt = 8'd0;
        if (w_coin_val != 5'd0) begin
          if (w_paid) begin
            w_state_nxt  = ST_DISPENSE;
            w_credit_nxt = w_sum[3:0] - LP_PRICE[3:0];
          end else begin
            w_state_nxt  = ST_COLLECT;
            w_credit_nxt = w_sum[3:0];
          end
        end
      end
      ST_COLLECT: begin
        // Cancel outranks payment so a customer can always back out with the last coin.
        if (bus.cancel) begin
          w_state_nxt  = ST_CHANGE;
          w_credit_nxt = w_sum[3:0];
          w_tmo_nxt    = 8'd0;
        end else if ((w_coin_val != 5'd0) && w_paid) begin
          w_state_nxt  = ST_DISPENSE;
          w_credit_nxt = w_sum[3:0] - LP_PRICE[3:0];
          w_tmo_nxt    = 8'd0;
        end else if (w_coin_val != 5'd0) begin
          w_credit_nxt = w_sum[3:0];
          w_tmo_nxt    = 8'd0;
        end else if (r_tmo == LP_TMO_LAST) begin
          w_state_nxt = ST_CHANGE;
          w_tmo_nxt   = 8'd0;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      ST_DISPENSE: begin
        w_tmo_nxt = 8'd0;
        if (r_disp_req && bus.disp_ack) begin
          w_state_nxt = (r_credit != 4'd0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        w_tmo_nxt = 8'd0;
        if (r_credit == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else if (r_chg_req && bus.chg_ack) begin
          w_credit_nxt = r_credit - 4'd1;
          if (r_credit == 4'd1) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_credit_nxt = 4'd0;
        w_tmo_nxt    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= 4'd0;
      r_tmo      <= 8'd0;
      r_disp_req <= 1'b0;
      r_chg_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_coin_rej <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_tmo      <= w_tmo_nxt;
      r_disp_req <= (w_state_nxt == ST_DISPENSE);
      r_chg_req  <= (w_state_nxt == ST_CHANGE) && (w_credit_nxt != 4'd0);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_coin_rej <= w_coin_rej;
    end
  end

  assign bus.credit   = r_credit;
  assign bus.disp_req = r_disp_req;
  assign bus.chg_req  = r_chg_req;
  assign bus.busy     = r_busy;
  assign bus.coin_rej = r_coin_rej;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - scoreboard bench for vend_sequencer with a behavioural vending model
module tb_vend_sequencer;
  localparam int PRICE   = 3;
  localparam int TIMEOUT = 200;

  typedef struct packed {
    logic [3:0] credit;
    logic       disp_req;
    logic       chg_req;
    logic       busy;
    logic       coin_rej;
  } obs_t;

  logic clk;
  logic rst;
  vend_sequencer_if bus ();

  vend_sequencer #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  // Model: mode 0 idle, 1 collecting, 2 waiting for dispenser, 3 paying back.
  int m_mode   = 0;
  int m_credit = 0;
  int m_idle   = 0;

  function automatic obs_t observe();
    obs_t o;
    o.credit   = bus.credit;
    o.disp_req = bus.disp_req;
    o.chg_req  = bus.chg_req;
    o.busy     = bus.busy;
    o.coin_rej = bus.coin_rej;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got credit=%0d dreq=%b creq=%b busy=%b rej=%b want credit=%0d dreq=%b creq=%b busy=%b rej=%b",
               name, $time, got.credit, got.disp_req, got.chg_req, got.busy, got.coin_rej,
               want.credit, want.disp_req, want.chg_req, want.busy, want.coin_rej);
    end
  endtask

  task automatic model_step(input logic [1:0] c, input logic cn, input logic da, input logic ca);
    int   val;
    obs_t e;
    val = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
    e.coin_rej = (c == 2'b11) || (c != 2'b00 && m_mode >= 2);
    if (m_mode == 0) begin
      if (val > 0) begin
        m_idle = 0;
        if (val >= PRICE) begin m_mode = 2; m_credit = val - PRICE; end
        else begin m_mode = 1; m_credit = val; end
      end
    end else if (m_mode == 1) begin
      if (cn) begin
        m_mode = 3; m_credit += val;
      end else if (val > 0) begin
        m_idle = 0;
        if (m_credit + val >= PRICE) begin m_mode = 2; m_credit = m_credit + val - PRICE; end
        else m_credit += val;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) m_mode = 3;
      end
    end else if (m_mode == 2) begin
      if (da) m_mode = (m_credit > 0) ? 3 : 0;
    end else begin
      if (ca) begin
        m_credit--;
        if (m_credit == 0) m_mode = 0;
      end
    end
    e.credit   = 4'(m_credit);
    e.disp_req = (m_mode == 2);
    e.chg_req  = (m_mode == 3);
    e.busy     = (m_mode != 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [1:0] c, input logic cn, input logic da, input logic ca);
    @(negedge clk);
    bus.coin = c; bus.cancel = cn; bus.disp_ack = da; bus.chg_ack = ca;
    @(posedge clk);
    model_step(c, cn, da, ca);
  endtask

  task automatic spot(input string name, input int cr, input logic dr, input logic chr, input logic bz);
    obs_t w;
    obs_t g;
    #2;
    g = observe();
    w = '{credit: 4'(cr), disp_req: dr, chg_req: chr, busy: bz, coin_rej: g.coin_rej};
    compare(name, g, w);
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.coin = 2'b00; bus.cancel = 1'b0; bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
    #2 rst = 1'b1;
    #1 compare("async_reset", observe(), obs_t'(8'h00));
    m_mode = 0; m_credit = 0; m_idle = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) compare("scoreboard", observe(), exp_q.pop_front());
  end

  initial begin
    int r;
    rst = 1'b1;
    bus.coin = 2'b00; bus.cancel = 1'b0; bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
    #1 compare("reset_state", observe(), obs_t'(8'h00));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(2'b01, 0, 0, 0); step(2'b01, 0, 0, 0); step(2'b01, 0, 0, 0);
    spot("exact_pay", 0, 1, 0, 1);
    step(2'b00, 0, 1, 0);
    spot("exact_pay_done", 0, 0, 0, 0);

    step(2'b10, 0, 0, 0); step(2'b10, 0, 0, 0);
    spot("overpay", 1, 1, 0, 1);
    step(2'b00, 0, 1, 0);
    spot("overpay_change", 1, 0, 1, 1);
    step(2'b00, 0, 0, 1);
    spot("overpay_done", 0, 0, 0, 0);

    step(2'b00, 1, 0, 0);
    step(2'b01, 0, 0, 0); step(2'b10, 1, 0, 0);
    spot("cancel", 3, 0, 1, 1);
    repeat (3) step(2'b00, 0, 0, 1);
    spot("cancel_done", 0, 0, 0, 0);

    step(2'b01, 0, 0, 0);
    repeat (TIMEOUT - 1) step(2'b00, 0, 1, 1);
    spot("timeout_edge", 1, 0, 0, 1);
    step(2'b00, 0, 0, 0);
    spot("timeout", 1, 0, 1, 1);
    step(2'b00, 0, 0, 1);

    step(2'b11, 0, 0, 0);
    step(2'b10, 0, 0, 0); step(2'b10, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    spot("reject_in_dispense", 1, 1, 0, 1);
    async_reset();

    for (int i = 0; i < 4000; i++) begin
      logic [1:0] c;
      r = $urandom_range(0, 9);
      c = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      step(c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
